// File: rtl/ethernet_tx_mmio_driver.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_tx_mmio_driver
// Description : Host-side MMIO master that pushes one outgoing Ethernet frame
//               into the controller's TX packet buffer. It waits for the TX
//               buffer to be free by polling the status register, writes the
//               frame words into the buffer, then writes the frame size and
//               the send command.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          : clock
//   reset_i        : synchronous active-high reset
//   frame_data_i   : stream word, bytes little-endian
//   frame_keep_i   : valid-byte mask of the stream word (contiguous from bit 0)
//   frame_v_i      : stream word valid
//   frame_last_i   : stream word is the last of the frame
//   frame_ready_o  : stream word accepted when frame_v_i & frame_ready_o
//   addr_o         : MMIO byte address
//   write_en_o     : MMIO write strobe
//   read_en_o      : MMIO read strobe
//   write_mask_o   : MMIO byte write mask
//   write_data_o   : MMIO write data
//   read_data_i    : MMIO read data, valid the cycle after read_en_o
//   busy_o         : block is not idle
//   frame_sent_o   : one-cycle pulse when the send command is written
//   frame_err_o    : one-cycle pulse when a frame is dropped
// ============================================================================
module ethernet_tx_mmio_driver #(
  parameter int                      data_width_p     = 32,
  parameter int                      eth_mtu_p        = 2048,
  parameter int                      addr_width_p     = 14,
  parameter logic [addr_width_p-1:0] tx_status_addr_p = 14'h0810,
  parameter logic [addr_width_p-1:0] tx_size_addr_p   = 14'h0814,
  parameter logic [addr_width_p-1:0] tx_send_addr_p   = 14'h0818,
  parameter logic [addr_width_p-1:0] tx_buf_addr_p    = 14'h1000
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [data_width_p-1:0]   frame_data_i,
  input  logic [data_width_p/8-1:0] frame_keep_i,
  input  logic                      frame_v_i,
  input  logic                      frame_last_i,
  output logic                      frame_ready_o,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      write_en_o,
  output logic                      read_en_o,
  output logic [data_width_p/8-1:0] write_mask_o,
  output logic [data_width_p-1:0]   write_data_o,
  input  logic [data_width_p-1:0]   read_data_i,
  output logic                      busy_o,
  output logic                      frame_sent_o,
  output logic                      frame_err_o
);

  localparam int C_BYTES     = data_width_p / 8;
  localparam int C_BYTE_W    = $clog2(eth_mtu_p + 1);
  localparam int C_MAX_WORDS = eth_mtu_p / C_BYTES;
  localparam int C_WIDX_W    = $clog2(C_MAX_WORDS + 1);
  localparam int C_OFF_SH    = $clog2(C_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POLL  = 3'd1,
    S_CHECK = 3'd2,
    S_FILL  = 3'd3,
    S_SIZE  = 3'd4,
    S_SEND  = 3'd5,
    S_DRAIN = 3'd6
  } state_e;

  state_e              state_q,    state_d;
  logic [C_BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [C_WIDX_W-1:0] word_idx_q, word_idx_d;

  logic [C_BYTE_W-1:0]     w_keep_pop;
  logic [C_BYTE_W-1:0]     w_byte_sum;
  logic                    w_overflow;
  logic [addr_width_p-1:0] w_buf_addr;
  logic                    w_unused_read;

  // Only the "buffer free" flag of the status register is meaningful here.
  assign w_unused_read = ^read_data_i[data_width_p-1:1];

  always_comb begin
    w_keep_pop = '0;
    for (int i = 0; i < C_BYTES; i++) begin
      w_keep_pop = w_keep_pop + C_BYTE_W'(frame_keep_i[i]);
    end
  end

  assign w_byte_sum = byte_cnt_q + w_keep_pop;

  // The buffer holds exactly C_MAX_WORDS words; a word arriving at this index
  // has nowhere to go and marks the frame as oversized.
  assign w_overflow = (word_idx_q == C_WIDX_W'(C_MAX_WORDS));

  assign w_buf_addr = tx_buf_addr_p + (addr_width_p'(word_idx_q) << C_OFF_SH);

  assign busy_o = (state_q != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_idx_d    = word_idx_q;
    frame_ready_o = 1'b0;
    write_en_o    = 1'b0;
    read_en_o     = 1'b0;
    addr_o        = '0;
    write_mask_o  = '0;
    write_data_o  = '0;
    frame_sent_o  = 1'b0;
    frame_err_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The pending word stays on the stream until FILL accepts it.
        if (frame_v_i) begin
          state_d = S_POLL;
        end
      end

      S_POLL: begin
        read_en_o = 1'b1;
        addr_o    = tx_status_addr_p;
        state_d   = S_CHECK;
      end

      S_CHECK: begin
        state_d = read_data_i[0] ? S_FILL : S_POLL;
      end

      S_FILL: begin
        frame_ready_o = 1'b1;
        if (frame_v_i) begin
          if (w_overflow) begin
            if (frame_last_i) begin
              frame_err_o = 1'b1;
              byte_cnt_d  = '0;
              word_idx_d  = '0;
              state_d     = S_IDLE;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            write_en_o   = 1'b1;
            addr_o       = w_buf_addr;
            write_mask_o = frame_keep_i;
            write_data_o = frame_data_i;
            word_idx_d   = word_idx_q + 1'b1;
            byte_cnt_d   = w_byte_sum;
            if (frame_last_i) begin
              if (w_byte_sum == '0) begin
                // Nothing worth sending: drop instead of issuing a zero-size send.
                frame_err_o = 1'b1;
                byte_cnt_d  = '0;
                word_idx_d  = '0;
                state_d     = S_IDLE;
              end else begin
                state_d = S_SIZE;
              end
            end
          end
        end
      end

      S_SIZE: begin
        write_en_o   = 1'b1;
        addr_o       = tx_size_addr_p;
        write_mask_o = '1;
        write_data_o = data_width_p'(byte_cnt_q);
        state_d      = S_SEND;
      end

      S_SEND: begin
        write_en_o   = 1'b1;
        addr_o       = tx_send_addr_p;
        write_mask_o = '1;
        write_data_o = data_width_p'(1);
        frame_sent_o = 1'b1;
        byte_cnt_d   = '0;
        word_idx_d   = '0;
        state_d      = S_IDLE;
      end

      S_DRAIN: begin
        frame_ready_o = 1'b1;
        if (frame_v_i && frame_last_i) begin
          frame_err_o = 1'b1;
          byte_cnt_d  = '0;
          word_idx_d  = '0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ethernet_tx_mmio_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ethernet_tx_mmio_driver
// Description : Self-checking bench for ethernet_tx_mmio_driver. Expected MMIO
//               transactions are queued when a frame is launched and compared
//               in order as the DUT issues strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_tx_mmio_driver;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] frame_data_i;
  logic [3:0]  frame_keep_i;
  logic        frame_v_i;
  logic        frame_last_i;
  logic        frame_ready_o;
  logic [13:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [3:0]  write_mask_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;
  logic        busy_o;
  logic        frame_sent_o;
  logic        frame_err_o;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  int   polls_seen = 0;
  int   free_at_poll = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_latency = 0;
  int   sent_cnt = 0;
  int   err_cnt = 0;
  logic busy_prev = 1'b0;
  bit   mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  ethernet_tx_mmio_driver dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .frame_data_i (frame_data_i),
    .frame_keep_i (frame_keep_i),
    .frame_v_i    (frame_v_i),
    .frame_last_i (frame_last_i),
    .frame_ready_o(frame_ready_o),
    .addr_o       (addr_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .write_mask_o (write_mask_o),
    .write_data_o (write_data_o),
    .read_data_i  (read_data_i),
    .busy_o       (busy_o),
    .frame_sent_o (frame_sent_o),
    .frame_err_o  (frame_err_o)
  );

  // Controller status model: buffer reports busy until poll number free_at_poll.
  // Upper bits carry noise so only bit 0 can matter.
  always @(posedge clk_i) begin
    if (reset_i) begin
      read_data_i <= 32'h0;
    end else if (read_en_o) begin
      read_data_i <= {$urandom(), 1'b0} | 32'(polls_seen >= free_at_poll);
      polls_seen  <= polls_seen + 1;
    end else begin
      read_data_i <= {$urandom(), 1'b0};
    end
  end

  // Bus monitor / scoreboard consumer.
  always @(negedge clk_i) begin
    txn_t e;
    cyc = cyc + 1;
    if (mon_en) begin
      checks = checks + 1;
      if (write_en_o && read_en_o) begin
        errors = errors + 1;
        $display("FAIL strobe_exclusive: write_en=%b read_en=%b, required not both", write_en_o, read_en_o);
      end
      if (write_en_o || read_en_o) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_strobe: we=%b re=%b addr=%h mask=%h data=%h, required no strobe",
                   write_en_o, read_en_o, addr_o, write_mask_o, write_data_o);
        end else begin
          e = exp_q.pop_front();
          if (e.we) begin
            if ({read_en_o, write_en_o, addr_o, write_mask_o, write_data_o} !==
                {1'b0, 1'b1, e.addr, e.mask, e.data}) begin
              errors = errors + 1;
              $display("FAIL mmio_write: got re=%b we=%b addr=%h mask=%h data=%h, required write addr=%h mask=%h data=%h",
                       read_en_o, write_en_o, addr_o, write_mask_o, write_data_o, e.addr, e.mask, e.data);
            end
          end else begin
            if ({read_en_o, write_en_o, addr_o} !== {1'b1, 1'b0, e.addr}) begin
              errors = errors + 1;
              $display("FAIL mmio_read: got re=%b we=%b addr=%h, required read addr=%h",
                       read_en_o, write_en_o, addr_o, e.addr);
            end
          end
        end
      end else begin
        checks = checks + 1;
        if ({addr_o, write_mask_o, write_data_o} !== 50'h0) begin
          errors = errors + 1;
          $display("FAIL idle_bus: addr=%h mask=%h data=%h, required all zero", addr_o, write_mask_o, write_data_o);
        end
      end
      checks = checks + 1;
      if (frame_sent_o && frame_err_o) begin
        errors = errors + 1;
        $display("FAIL sent_err_exclusive: sent=%b err=%b, required not both", frame_sent_o, frame_err_o);
      end
      if (frame_sent_o === 1'b1) begin
        sent_cnt     = sent_cnt + 1;
        last_latency = cyc - start_cyc + 1;
      end
      if (frame_err_o === 1'b1) err_cnt = err_cnt + 1;
      if (busy_o && !busy_prev) start_cyc = cyc;
      busy_prev = busy_o;
    end
  end

  // Launch one frame, queue its expected MMIO traffic, stream it, and check outcome.
  task automatic run_frame(input int nwords, input logic [3:0] last_keep, input int busy,
                           input int gap_every, input string name);
    logic [31:0] dq[$];
    logic [3:0]  kq[$];
    int          nbytes;
    bit          exp_err;
    int          sent0, err0, w, budget;
    bit          acc;
    nbytes = 0;
    for (int i = 0; i < nwords; i++) begin
      dq.push_back($urandom());
      kq.push_back((i == nwords - 1) ? last_keep : 4'hF);
      nbytes = nbytes + $countones(kq[i]);
    end
    exp_err = (nwords > 512) || (nbytes == 0);
    for (int i = 0; i <= busy; i++) exp_q.push_back('{1'b0, 14'h0810, 4'h0, 32'h0});
    for (int i = 0; i < nwords && i < 512; i++)
      exp_q.push_back('{1'b1, 14'(14'h1000 + 4 * i), kq[i], dq[i]});
    if (!exp_err) begin
      exp_q.push_back('{1'b1, 14'h0814, 4'hF, 32'(nbytes)});
      exp_q.push_back('{1'b1, 14'h0818, 4'hF, 32'h1});
    end
    sent0 = sent_cnt;
    err0  = err_cnt;
    @(posedge clk_i); #1;
    free_at_poll = polls_seen + busy;
    w = 0;
    budget = nwords * 8 + busy * 4 + 50;
    while (w < nwords && budget > 0) begin
      frame_data_i = dq[w];
      frame_keep_i = kq[w];
      frame_last_i = (w == nwords - 1);
      frame_v_i    = (gap_every == 0) || ($urandom_range(0, gap_every - 1) != 0);
      @(negedge clk_i);
      acc = frame_v_i && frame_ready_o;
      @(posedge clk_i); #1;
      if (acc) w++;
      budget--;
    end
    frame_v_i = 1'b0; frame_last_i = 1'b0; frame_keep_i = 4'h0; frame_data_i = 32'h0;
    checks++;
    if (w != nwords) begin
      errors++;
      $display("FAIL %s_stream_timeout: accepted %0d words, required %0d", name, w, nwords);
    end
    budget = 20;
    do begin
      @(negedge clk_i);
      budget--;
    end while (busy_o && budget > 0);
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy_o);
    end
    checks++;
    if (sent_cnt - sent0 != (exp_err ? 0 : 1)) begin
      errors++;
      $display("FAIL %s_sent_pulses: got %0d, required %0d", name, sent_cnt - sent0, exp_err ? 0 : 1);
    end
    checks++;
    if (err_cnt - err0 != (exp_err ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_err_pulses: got %0d, required %0d", name, err_cnt - err0, exp_err ? 1 : 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_txn: %0d expected transactions not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
    if (!exp_err && gap_every == 0) begin
      checks++;
      if (last_latency != nwords + 4 + 2 * busy) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, last_latency, nwords + 4 + 2 * busy);
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    frame_v_i = 1'b0; frame_last_i = 1'b0; frame_keep_i = 4'h0; frame_data_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({frame_ready_o, write_en_o, read_en_o, busy_o, frame_sent_o, frame_err_o} !== 6'b0 ||
        {addr_o, write_mask_o, write_data_o} !== 50'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b re=%b busy=%b sent=%b err=%b addr=%h mask=%h data=%h, required all 0",
               frame_ready_o, write_en_o, read_en_o, busy_o, frame_sent_o, frame_err_o, addr_o, write_mask_o, write_data_o);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    mon_en  = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(15, 4'hF, 0, 0, "frame60");
  endtask

  task automatic test_partial_keep();
    run_frame(16, 4'b0001, 0, 0, "frame61");
  endtask

  task automatic test_busy_poll();
    run_frame(15, 4'hF, 3, 0, "busy3");
  endtask

  task automatic test_stream_gaps();
    run_frame(10, 4'b0111, 1, 3, "gaps");
  endtask

  task automatic test_overflow();
    run_frame(513, 4'hF, 0, 0, "ovf_last");
    run_frame(515, 4'hF, 0, 0, "ovf_drain");
  endtask

  task automatic test_empty_frame();
    run_frame(1, 4'h0, 0, 0, "empty");
    run_frame(4, 4'b0011, 0, 0, "after_empty");
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int          w, budget;
    bit          acc;
    exp_q.push_back('{1'b0, 14'h0810, 4'h0, 32'h0});
    @(posedge clk_i); #1;
    free_at_poll = polls_seen;
    w = 0;
    budget = 60;
    d = $urandom();
    while (w < 5 && budget > 0) begin
      frame_data_i = d; frame_keep_i = 4'hF; frame_last_i = 1'b0; frame_v_i = 1'b1;
      @(negedge clk_i);
      acc = frame_ready_o;
      if (acc) exp_q.push_back('{1'b1, 14'(14'h1000 + 4 * w), 4'hF, d});
      @(posedge clk_i); #1;
      if (acc) begin
        w++;
        d = $urandom();
      end
      budget--;
    end
    checks++;
    if (w != 5) begin
      errors++;
      $display("FAIL midreset_stream_timeout: accepted %0d words, required 5", w);
    end
    frame_v_i = 1'b0;
    reset_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({busy_o, frame_ready_o, write_en_o, read_en_o} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b rdy=%b we=%b re=%b, required all 0",
               busy_o, frame_ready_o, write_en_o, read_en_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_missing_txn: %0d expected transactions not seen, required 0", exp_q.size());
      exp_q.delete();
    end
    run_frame(16, 4'hF, 0, 0, "after_reset64");
  endtask

  task automatic test_back_to_back();
    run_frame(2, 4'b0111, 0, 0, "b2b_a");
    run_frame(3, 4'hF, 1, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_keep();
    test_busy_poll();
    test_stream_gaps();
    test_overflow();
    test_empty_frame();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ethernet_tx_mmio_driver.md
# ethernet_tx_mmio_driver

Host-side initiator for the Ethernet controller's memory-mapped register port: accepts an outgoing frame as a ready/valid word stream, waits until the controller's TX buffer is free, copies the frame into the TX packet buffer with MMIO writes, then writes the frame size and the send command. It sits between a frame source (test harness, DMA, or accelerator) and the controller's `addr/write_en/read_en/write_mask/write_data/read_data` slave port, and drives that port as its only master.

## Interface
Parameters:
- `data_width_p`, 32: MMIO and stream word width (32 or 64).
- `eth_mtu_p`, 2048: maximum frame size in bytes.
- `addr_width_p`, 14: MMIO byte-address width.
- `tx_status_addr_p`, 14'h0810: status register; `read_data_i[0]`=1 means the TX buffer is free.
- `tx_size_addr_p`, 14'h0814: frame-size register.
- `tx_send_addr_p`, 14'h0818: send-command register (write 1).
- `tx_buf_addr_p`, 14'h1000: base byte address of the TX packet buffer.

Ports:
- `clk_i` in 1: the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `frame_data_i` in `data_width_p`: frame word, bytes little-endian.
- `frame_keep_i` in `data_width_p/8`: valid-byte mask, contiguous from bit 0; all-ones except on the last word.
- `frame_v_i` in 1: word valid.
- `frame_last_i` in 1: final word of frame.
- `frame_ready_o` out 1: word accepted when `frame_v_i & frame_ready_o`.
- `addr_o` out `addr_width_p`: MMIO byte address.
- `write_en_o` out 1, `read_en_o` out 1: MMIO strobes, never both high.
- `write_mask_o` out `data_width_p/8`, `write_data_o` out `data_width_p`: MMIO write payload.
- `read_data_i` in `data_width_p`: synchronous read data, valid the cycle after `read_en_o`.
- `busy_o` out 1: high in any state except IDLE.
- `frame_sent_o` out 1: one-cycle pulse when the send command is written.
- `frame_err_o` out 1: one-cycle pulse when a frame is dropped.

## Operation
- States: IDLE, POLL, CHECK, FILL, SIZE, SEND, DRAIN.
- IDLE: when `frame_v_i`=1, go to POLL. The word is not consumed.
- POLL: assert `read_en_o` with `addr_o`=`tx_status_addr_p`, then go to CHECK.
- CHECK: sample `read_data_i[0]`. If 1, go to FILL; if 0, go to POLL. Polling repeats until the buffer is free; there is no timeout.
- FILL:
  - `frame_ready_o`=1. Each accepted word issues a write in the same cycle.
  - Write fields: `addr_o`=`tx_buf_addr_p + word_idx*(data_width_p/8)`, `write_mask_o`=`frame_keep_i`, `write_data_o`=`frame_data_i`.
  - `word_idx` increments; `byte_cnt += popcount(frame_keep_i)`.
  - On an accepted last word, go to SIZE.
- SIZE: write `byte_cnt` (zero-extended, full mask) to `tx_size_addr_p`, then go to SEND.
- SEND: write 1 (full mask) to `tx_send_addr_p`, pulse `frame_sent_o`, clear the counters, return to IDLE.
- Counter widths: `byte_cnt` is `$clog2(eth_mtu_p+1)` bits; `word_idx` is `$clog2(eth_mtu_p/(data_width_p/8)+1)` bits.
- Overflow: an accepted word with `word_idx` = `eth_mtu_p/(data_width_p/8)` issues no write.
  - If that word is not last, go to DRAIN.
  - If it is last, pulse `frame_err_o` and go to IDLE. SIZE and SEND are skipped.
- DRAIN: `frame_ready_o`=1 and words are discarded with no MMIO activity. On an accepted last word, pulse `frame_err_o`, clear the counters, go to IDLE.
- Empty frame: if the last word is accepted with `byte_cnt`=0 after its keep is added, skip SIZE/SEND, pulse `frame_err_o`, go to IDLE.
- In FILL with `frame_v_i`=0: no strobe, state held. Gaps in the stream are allowed.
- All outputs are combinational from state, counters and stream inputs. The only registers are the state and the counters.

## Timing
- Reset values: state IDLE, counters 0; `frame_ready_o`, `write_en_o`, `read_en_o`, `busy_o`, `frame_sent_o`, `frame_err_o` all 0. `addr_o`, `write_mask_o`, `write_data_o` are 0 whenever no strobe is asserted.
- Reset mid-frame aborts the frame: the block is in IDLE with no strobe in the cycle after reset deasserts. Words already written are not retracted.
- Minimum poll round trip: 2 cycles (POLL, CHECK).
- An N-word frame with the buffer free on the first poll takes N+4 cycles from leaving IDLE to `frame_sent_o`, with no stream bubbles.
- At most one MMIO strobe per cycle. Write data and mask must be accepted by the controller in the same cycle (no backpressure).
- `frame_sent_o` and `frame_err_o` are never high in the same cycle.

## Test plan
- 60-byte frame, 32-bit, buffer free on first poll, keep=4'hF×14 then 4'hF on word 15 → 15 writes to 0x1000..0x1038, size write 60 to 0x0814, send write 1 to 0x0818, `frame_sent_o` at cycle 19 after leaving IDLE.
- 61-byte frame, last keep=4'b0001 → last write has mask 4'b0001, size write = 61.
- Status reads 0 three times, then 1 → exactly 4 `read_en_o` pulses, `frame_ready_o` stays 0 until the 4th CHECK, then normal fill.
- 2052-byte frame (513 words) → 512 writes (last to 0x17FC), word 513 is not written, no size/send writes, `frame_err_o` pulses once, then IDLE.
- Single word with keep=0 and last → one write with mask 0, `frame_err_o`, no send; next valid frame is sent normally.
- `reset_i` asserted during FILL at word 5 → no strobes after reset, `busy_o`=0; a following 64-byte frame writes from `word_idx` 0 with size 64.
